// File: rtl/gru_output_dense.sv
// Output projection behind the GRU hidden layer: y = Wy*h + by on one shared
// saturating MAC, with a timestep counter that flags the last step of a sequence.
module gru_output_dense #(
    parameter int unsigned CELLNUM = 4,
    parameter int unsigned OUTNUM  = 2,
    parameter int unsigned DATABIT = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned STEP    = 10,
    parameter int unsigned ACCBIT  = 40,
    localparam int unsigned STEPW  = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                h_finish,
    input  logic [CELLNUM*DATABIT-1:0]          h,
    input  logic [OUTNUM*CELLNUM*DATABIT-1:0]   wy,
    input  logic [OUTNUM*DATABIT-1:0]           by,
    input  logic                                seq_clr,
    output logic [OUTNUM*DATABIT-1:0]           y,
    output logic                                y_valid,
    output logic                                seq_done,
    output logic [STEPW-1:0]                    step_cnt,
    output logic                                busy,
    output logic                                overrun
);

    localparam int unsigned CW = (CELLNUM > 1) ? $clog2(CELLNUM) : 1;
    localparam int unsigned OW = (OUTNUM > 1) ? $clog2(OUTNUM) : 1;
    localparam int unsigned PW = 2 * DATABIT;

    localparam logic signed [ACCBIT-1:0] SAT_HI = {{(ACCBIT-DATABIT+1){1'b0}}, {(DATABIT-1){1'b1}}};
    localparam logic signed [ACCBIT-1:0] SAT_LO = {{(ACCBIT-DATABIT+1){1'b1}}, {(DATABIT-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                       hf_d;
    logic                       start_c;
    logic                       load_c, mac_c, done_c, drop_c;
    logic                       last_c, last_o;
    logic [CW-1:0]              c_idx;
    logic [OW-1:0]              o_idx;
    logic [OW-1:0]              o_nxt;
    logic signed [ACCBIT-1:0]   acc;
    logic signed [ACCBIT-1:0]   acc_nxt;
    logic signed [PW-1:0]       prod_c;

    logic signed [DATABIT-1:0]  h_in   [CELLNUM];
    logic signed [DATABIT-1:0]  h_lat  [CELLNUM];
    logic signed [DATABIT-1:0]  wy_arr [OUTNUM][CELLNUM];
    logic signed [DATABIT-1:0]  by_arr [OUTNUM];
    logic signed [DATABIT-1:0]  y_buf  [OUTNUM];

    // Bias aligned to the accumulator's fixed-point position
    function automatic logic signed [ACCBIT-1:0] bias_ext(input logic signed [DATABIT-1:0] b);
        return ACCBIT'(b) <<< FRAC;
    endfunction

    function automatic logic signed [DATABIT-1:0] sat(input logic signed [ACCBIT-1:0] a);
        if (a > SAT_HI)
            return {1'b0, {(DATABIT-1){1'b1}}};
        else if (a < SAT_LO)
            return {1'b1, {(DATABIT-1){1'b0}}};
        else
            return a[DATABIT-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < CELLNUM; c++)
            h_in[c] = h[c*DATABIT +: DATABIT];
        for (int o = 0; o < OUTNUM; o++) begin
            by_arr[o] = by[o*DATABIT +: DATABIT];
            for (int c = 0; c < CELLNUM; c++)
                wy_arr[o][c] = wy[(o*CELLNUM+c)*DATABIT +: DATABIT];
        end
    end

    assign start_c = h_finish & ~hf_d;
    assign last_c  = (c_idx == CW'(CELLNUM-1));
    assign last_o  = (o_idx == OW'(OUTNUM-1));
    assign o_nxt   = o_idx + OW'(1);
    assign prod_c  = PW'(h_lat[c_idx]) * PW'(wy_arr[o_idx][c_idx]);
    assign acc_nxt = acc + ACCBIT'(prod_c);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_c) state_nxt = S_MAC;
            S_MAC:  if (last_c && last_o) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load_c = 1'b0;
        mac_c  = 1'b0;
        done_c = 1'b0;
        drop_c = 1'b0;
        case (state)
            S_IDLE: load_c = start_c;
            S_MAC:  begin mac_c = 1'b1;  drop_c = start_c; end
            S_DONE: begin done_c = 1'b1; drop_c = start_c; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hf_d     <= 1'b0;
            y        <= '0;
            y_valid  <= 1'b0;
            seq_done <= 1'b0;
            step_cnt <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            acc      <= '0;
            c_idx    <= '0;
            o_idx    <= '0;
            for (int c = 0; c < CELLNUM; c++) h_lat[c] <= '0;
            for (int o = 0; o < OUTNUM; o++)  y_buf[o] <= '0;
        end else begin
            hf_d    <= h_finish;
            y_valid <= done_c;
            busy    <= (state_nxt != S_IDLE);

            if (load_c) begin
                for (int c = 0; c < CELLNUM; c++) h_lat[c] <= h_in[c];
                c_idx <= '0;
                o_idx <= '0;
                acc   <= bias_ext(by_arr[0]);
            end

            // Close out one output row per CELLNUM products, then preload the next bias
            if (mac_c) begin
                if (last_c) begin
                    y_buf[o_idx] <= sat(acc_nxt >>> FRAC);
                    c_idx        <= '0;
                    o_idx        <= o_nxt;
                    acc          <= last_o ? '0 : bias_ext(by_arr[o_nxt]);
                end else begin
                    c_idx <= c_idx + CW'(1);
                    acc   <= acc_nxt;
                end
            end

            if (done_c) begin
                for (int o = 0; o < OUTNUM; o++) y[o*DATABIT +: DATABIT] <= y_buf[o];
            end

            // A clear in the same cycle as DONE wins over the wrap pulse
            seq_done <= done_c && !seq_clr && (step_cnt == STEPW'(STEP-1));
            if (seq_clr)
                step_cnt <= '0;
            else if (done_c)
                step_cnt <= (step_cnt == STEPW'(STEP-1)) ? '0 : step_cnt + STEPW'(1);

            if (seq_clr)
                overrun <= 1'b0;
            else if (drop_c)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gru_output_dense.sv
// Scoreboard bench for gru_output_dense: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every y_valid.
module tb_gru_output_dense;

    logic         clk;
    logic         rst;
    logic         h_finish;
    logic [63:0]  h;
    logic [127:0] wy;
    logic [31:0]  by;
    logic         seq_clr;
    logic [31:0]  y;
    logic         y_valid;
    logic         seq_done;
    logic [3:0]   step_cnt;
    logic         busy;
    logic         overrun;

    gru_output_dense dut (
        .clk      (clk),
        .rst      (rst),
        .h_finish (h_finish),
        .h        (h),
        .wy       (wy),
        .by       (by),
        .seq_clr  (seq_clr),
        .y        (y),
        .y_valid  (y_valid),
        .seq_done (seq_done),
        .step_cnt (step_cnt),
        .busy     (busy),
        .overrun  (overrun)
    );

    typedef struct {
        logic [31:0] y;
        logic        sd;
        logic [3:0]  st;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_step = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Monitor: every y_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (y_valid) begin
            if (q.size() == 0) begin
                check("unexpected_y_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("y", 64'(y), 64'(e.y));
                check("seq_done", 64'(seq_done), 64'(e.sd));
                check("step_cnt", 64'(step_cnt), 64'(e.st));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end else if (seq_done) begin
            check("seq_done_without_valid", 64'(seq_done), 64'd0);
        end
    end

    function automatic exp_t mk_exp(input logic [31:0] yv, input int c0);
        exp_t e;
        e.y   = yv;
        e.sd  = (exp_step == 9);
        e.st  = (exp_step == 9) ? 4'd0 : 4'(exp_step + 1);
        e.cyc = c0 + 10;
        return e;
    endfunction

    // One accepted computation; inputs held for the whole gap
    task automatic issue(input logic [63:0] hv, input logic [127:0] wv, input logic [31:0] bv,
                         input logic [31:0] yexp, input int gap);
        exp_t e;
        @(negedge clk);
        h = hv; wy = wv; by = bv; h_finish = 1'b1;
        e = mk_exp(yexp, cyc);
        q.push_back(e);
        exp_step = e.st;
        @(negedge clk);
        h_finish = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic do_seq_clr();
        @(negedge clk);
        seq_clr = 1'b1;
        @(negedge clk);
        seq_clr = 1'b0;
        exp_step = 0;
    endtask

    localparam logic [127:0] WY_BASIC = {rep4(16'hFF00), rep4(16'h0100)};
    localparam logic [31:0]  Y_BASIC  = {16'hFC00, 16'h0480};

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b1; h_finish = 1'b0; seq_clr = 1'b0;
        h = '0; wy = '0; by = '0;
        repeat (3) @(negedge clk);
        check("rst_y", 64'(y), 64'd0);
        check("rst_y_valid", 64'(y_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_step_cnt", 64'(step_cnt), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_seq_done", 64'(seq_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic, saturation and truncation vectors
        issue(rep4(16'h0100), WY_BASIC, {16'h0000, 16'h0080}, Y_BASIC, 20);
        check("idle_busy", 64'(busy), 64'd0);
        check("y_held", 64'(y), 64'(Y_BASIC));
        issue(rep4(16'h7FFF), {rep4(16'h7FFF), rep4(16'h7FFF)}, 32'h0, {16'h7FFF, 16'h7FFF}, 20);
        issue(rep4(16'h7FFF), {rep4(16'h8000), rep4(16'h7FFF)}, 32'h0, {16'h8000, 16'h7FFF}, 20);
        issue({48'h0, 16'h0001}, {112'h0, 16'h0080}, 32'h0, 32'h0000_0000, 20);
        issue({48'h0, 16'h0001}, {112'h0, 16'hFF80}, 32'h0, 32'h0000_FFFF, 20);

        // Full sequence: seq_done only on the 10th result
        do_seq_clr();
        check("seq_clr_step", 64'(step_cnt), 64'd0);
        for (int i = 0; i < 10; i++)
            issue(rep4(16'h0100), WY_BASIC, {16'h0000, 16'h0080}, Y_BASIC, 20);
        check("seq_wrap_step", 64'(step_cnt), 64'd0);

        // Mid-sequence clear restarts the count
        for (int i = 0; i < 3; i++)
            issue(rep4(16'h0100), WY_BASIC, {16'h0000, 16'h0080}, Y_BASIC, 20);
        check("mid_step", 64'(step_cnt), 64'd3);
        do_seq_clr();
        check("mid_clr_step", 64'(step_cnt), 64'd0);
        issue(rep4(16'h0100), WY_BASIC, {16'h0000, 16'h0080}, Y_BASIC, 20);

        // Overrun: second rising edge 3 cycles after the first is dropped
        begin
            exp_t e;
            @(negedge clk);
            h = rep4(16'h0100); wy = WY_BASIC; by = {16'h0000, 16'h0080}; h_finish = 1'b1;
            e = mk_exp(Y_BASIC, cyc);
            q.push_back(e);
            exp_step = e.st;
            @(negedge clk); h_finish = 1'b0;
            @(negedge clk);
            @(negedge clk); h = rep4(16'h0200); h_finish = 1'b1;
            @(negedge clk); h_finish = 1'b0;
            check("overrun_set", 64'(overrun), 64'd1);
            repeat (20) @(negedge clk);
            check("overrun_sticky", 64'(overrun), 64'd1);
            check("overrun_single_result", 64'(q.size()), 64'd0);
            do_seq_clr();
            check("overrun_cleared", 64'(overrun), 64'd0);
        end

        // Reset at MAC cycle 4 aborts without publishing
        @(negedge clk);
        h = rep4(16'h0100); wy = WY_BASIC; by = {16'h0000, 16'h0080}; h_finish = 1'b1;
        @(negedge clk); h_finish = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_y", 64'(y), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_step", 64'(step_cnt), 64'd0);
        rst = 1'b0;
        exp_step = 0;
        repeat (15) @(negedge clk);
        issue(rep4(16'h0100), WY_BASIC, {16'h0000, 16'h0080}, Y_BASIC, 20);
        check("post_abort_step", 64'(step_cnt), 64'd1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gru_output_dense.md
# gru_output_dense

Output projection stage directly downstream of the GRU hidden layer. It captures each new hidden-state vector `h` when the hidden layer's `h_finish` rises and computes `y = Wy·h + by` in signed fixed point. The computation uses one time-shared multiply-accumulate unit with saturating writeback. It also counts timesteps of a STEP-long sequence and flags the last one.

## Interface
Parameters:
- CELLNUM, 4, hidden cells per vector (width of `h`).
- OUTNUM, 2, output neurons.
- DATABIT, 16, signed word width.
- FRAC, 8, fractional bits (Q8.8 for defaults); h, wy, by and y all share this format.
- STEP, 10, timesteps per sequence.
- ACCBIT, 40, accumulator width.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- h_finish  in  1  level from hidden layer; a 0→1 transition marks a new valid `h`.
- h  in  CELLNUM*DATABIT  hidden vector; cell c at [c*DATABIT +: DATABIT].
- wy  in  OUTNUM*CELLNUM*DATABIT  weights; element (o,c) at [(o*CELLNUM+c)*DATABIT +: DATABIT]; must be held stable while busy.
- by  in  OUTNUM*DATABIT  bias; output o at [o*DATABIT +: DATABIT].
- seq_clr  in  1  synchronous clear of step counter and overrun flag.
- y  out  OUTNUM*DATABIT  result vector, same packing as by.
- y_valid  out  1  one-cycle pulse when `y` updates.
- seq_done  out  1  one-cycle pulse coincident with y_valid of step STEP-1.
- step_cnt  out  clog2(STEP)  index of the next timestep to be produced.
- busy  out  1  high while not in IDLE.
- overrun  out  1  sticky; a rising edge of h_finish was dropped.

## Operation
- Edge detect: register `hf_d` <= h_finish. `start` = h_finish & ~hf_d.
- FSM states:
  - IDLE: on `start`, latch `h` into `h_lat`, set o=0, c=0, load acc = sign-extended by[0] << FRAC, and go to MAC.
  - MAC: each cycle, acc += h_lat[c]*wy[o][c], a signed 2·DATABIT product sign-extended to ACCBIT.
    - If c < CELLNUM-1: c++.
    - Otherwise: y_buf[o] <= sat(acc_next >>> FRAC), c=0, acc = by[o+1] << FRAC, o++.
    - After the last element (o = OUTNUM-1, c = CELLNUM-1), go to DONE.
  - DONE: y <= y_buf, y_valid <= 1, then return to IDLE.
    - If step_cnt = STEP-1: step_cnt <= 0 and seq_done <= 1.
    - Otherwise: step_cnt++.
- sat(): arithmetic right shift (truncation toward −∞), then clamp to [−2^(DATABIT−1), 2^(DATABIT−1)−1].
- `start` while busy: the event is dropped and overrun <= 1. The current computation is unaffected. `h` is not re-sampled.
- h_finish held high produces no further starts; it must fall and rise again.
- seq_clr: step_cnt <= 0 and overrun <= 0 in the same cycle. An in-flight computation continues.
  - If seq_clr coincides with DONE, the clear wins: step_cnt = 0 and seq_done = 0.
- Reset values: y=0, y_valid=0, seq_done=0, step_cnt=0, busy=0, overrun=0, hf_d=0, FSM=IDLE, accumulator and y_buf = 0.
- Reset mid-computation aborts immediately with no y_valid. Partial results are never published.

## Timing
- N = OUTNUM*CELLNUM MAC cycles (8 at defaults).
- Edge E0 samples `start` in IDLE. MAC runs on edges E1..EN. DONE is entered at EN; y, y_valid and step update at EN+1.
- Latency: y_valid is high in the cycle after edge E0+N+1, which is 10 cycles after the h_finish rising edge is sampled at defaults.
- y_valid and seq_done are high for exactly one cycle. `y` holds its value until the next DONE.
- busy is high from E0+1 through the DONE cycle. A `start` sampled in the same cycle y_valid is asserted (FSM back in IDLE) is accepted.
- Minimum `start` spacing is N+2 cycles. The hidden layer's clk_18 cadence satisfies this.

## Test plan
- Basic: all h cells = 0x0100, wy row0 = 0x0100, row1 = 0xFF00, by = {0x0000, 0x0080} → after 10 cycles y[0] = 0x0480, y[1] = 0xFC00, with a single y_valid pulse.
- Saturation: h = 0x7FFF, wy = 0x7FFF everywhere → y = 0x7FFF per output. With row1 wy = 0x8000 → y[1] = 0x8000.
- Truncation: h[0] = 0x0001, wy[0][0] = 0x0080, others 0 → y[0] = 0x0000. Same case with wy = 0xFF80 → y[0] = 0xFFFF.
- Sequence: 10 starts, each spaced 20 cycles apart → step_cnt counts 1..9 then 0, and seq_done pulses only with the 10th y_valid. seq_clr mid-sequence → step_cnt = 0 and the count restarts.
- Overrun: a second h_finish rising edge 3 cycles after the first → only one y_valid, result matches the first h, and overrun = 1 until seq_clr.
- Reset at MAC cycle 4 → no y_valid; y, busy and step_cnt = 0. The next start computes correctly.
